mem_resp: RTL
=============

Name: mem_resp

Overview:
- Wait-state memory responder on the far side of the CPU's MAR/MDR memory interface; it serves the CPU's read/write requests.
- Holds 2^ADDR_W words. It latches one request at a time, waits a programmable number of wait states, performs the access, then raises Ready until the requester withdraws the request.
- Replaces the zero-latency combinational RAM so the main control unit can be exercised against slow memory.

Parameters:
ADDR_W, 7, word address width (memory depth 2^ADDR_W)
DATA_W, 32, data word width
WAIT_CYCLES, 2, wait states inserted between request latch and access (0..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
Addr  input  ADDR_W  word address from MAR
R  input  1  read request, level, held until Ready seen
W  input  1  write request, level, held until Ready seen
W_data  input  DATA_W  write data from MDR
R_data  output  DATA_W  registered read data, valid while Ready=1 after a read
Ready  output  1  access complete; held until R=W=0
Busy  output  1  request accepted and access not yet complete
Err  output  1  illegal request (R and W both high) sampled in IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, R_data=0, Ready=0, Busy=0, Err=0, wait counter=0. Memory array contents are not cleared.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - R^W=1: latch Addr, W_data and op (read/write); load counter=WAIT_CYCLES; Busy=1; go to WAIT. Err<=0.
  - R&W=1: no access, Err<=1, stay in IDLE.
  - R=W=0: Err<=0, stay in IDLE.
- WAIT:
  - counter!=0: decrement.
  - counter==0: perform the access on the latched address. A read loads R_data<=mem[addr]. A write does mem[addr]<=data and leaves R_data unchanged. Set Ready<=1, Busy<=0, go to HOLD.
  - Addr, W_data, R and W are ignored throughout WAIT; the latched copies are used.
- HOLD:
  - Ready stays 1 while R|W=1.
  - When R=W=0: Ready<=0, go to IDLE.
  - A new request needs at least one idle cycle after Ready falls. This prevents a repeated access from a held request.
- Latency: request sampled at edge N; access and Ready=1 at edge N+1+WAIT_CYCLES. WAIT_CYCLES=0 gives Ready after edge N+1.
- Busy and Ready are never both 1. Err is 1 only in IDLE.
- Address wraps naturally within ADDR_W bits; no out-of-range condition exists.
- A write followed by a read of the same address returns the new data.
- Reset asserted mid-access (WAIT) aborts the access: no memory write occurs, and the FSM returns to IDLE immediately.
- Reset asserted in HOLD drops Ready asynchronously.
- A request whose R/W is dropped during WAIT still completes. Ready then pulses for one cycle in HOLD before the FSM returns to IDLE.

Test Plan:
- Reset, then WAIT_CYCLES=2: W=1, Addr=5, W_data=0xDEADBEEF at edge 0 -> Busy=1 for edges 1-2, Ready=1 after edge 3, mem[5]=0xDEADBEEF; drop W -> Ready=0 next edge.
- Read Addr=5 after the write -> Ready after edge N+3, R_data=0xDEADBEEF held until R drops.
- Change Addr to 9 and W_data to 0 during WAIT of a write to Addr=3 -> mem[3] gets the originally latched data; mem[9] unchanged.
- R=W=1 in IDLE -> Err=1 next edge, Busy=0, Ready=0, no memory change. Release both -> Err=0.
- Assert rst during WAIT of a write to Addr=7 with 0x12345678 -> state IDLE, Busy=0, mem[7] keeps its old value; a subsequent read returns the old value.
- WAIT_CYCLES=0 and R held high continuously for 5 cycles on Addr=127 -> exactly one access, Ready high from edge 1 while R high; no second Busy until R=0 for one cycle.

Source files
------------

// File: rtl/mem_resp.sv
// mem_resp: wait-state memory responder for the CPU MAR/MDR interface.
// Latches one request at a time, waits WAIT_CYCLES, performs the access,
// then holds Ready until the requester withdraws R and W.
module mem_resp #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              R,
    input  logic              W,
    input  logic [DATA_W-1:0] W_data,
    output logic [DATA_W-1:0] R_data,
    output logic              Ready,
    output logic              Busy,
    output logic              Err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_wr;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_is_wr_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_ready_nxt;
    logic              w_busy_nxt;
    logic              w_err_nxt;
    logic              w_mem_we;

    assign R_data = r_rdata;
    assign Ready  = r_ready;
    assign Busy   = r_busy;
    assign Err    = r_err;

    // State and registered outputs; reset aborts any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_is_wr <= w_is_wr_nxt;
            r_rdata <= w_rdata_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Storage array; contents survive reset, and a write in flight is lost on reset.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_is_wr_nxt = r_is_wr;
        w_rdata_nxt = r_rdata;
        w_ready_nxt = r_ready;
        w_busy_nxt  = r_busy;
        w_err_nxt   = r_err;
        w_mem_we    = 1'b0;

        case (r_state)
            IDLE: begin
                if (R && W) begin
                    w_err_nxt = 1'b1;
                end else if (R || W) begin
                    w_addr_nxt  = Addr;
                    w_wdata_nxt = W_data;
                    w_is_wr_nxt = W;
                    w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = WAIT;
                end else begin
                    w_err_nxt = 1'b0;
                end
            end
            WAIT: begin
                // Live request inputs are ignored here; only latched copies are used.
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    if (r_is_wr) begin
                        w_mem_we = 1'b1;
                    end else begin
                        w_rdata_nxt = r_mem[r_addr];
                    end
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Returning through IDLE forces an idle cycle before the next access.
                if (!(R || W)) begin
                    w_ready_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_ready_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_err_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
